// File: rtl/apb_uart_slave.sv
// APB completer exposing a UART register file and an 8N1 transmitter/receiver.
// The receiver can be fed from the internal uart_tx line through the loopback bit.
module apb_uart_slave #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [10:0] DEF_BAUD = 11'd66
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic [WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0] pwdata,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  output logic             pready,
  output logic [WIDTH-1:0] prdata,
  input  logic             uart_rx,
  output logic             uart_tx
);
  localparam int unsigned CW       = 11;
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] MIN_N  = CW'(2);
  localparam logic [2:0] A_BAUD    = 3'd0;
  localparam logic [2:0] A_TXDATA  = 3'd1;
  localparam logic [2:0] A_STATUS  = 3'd2;
  localparam logic [2:0] A_RXDATA  = 3'd3;
  localparam logic [2:0] A_CTRL    = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic [CW-1:0] baud;
  logic          loopback;
  logic [7:0]    rxdata;
  logic          rx_valid, rx_overrun, rx_frame_err;

  uart_state_t   tx_state, rx_state;
  logic [CW-1:0] tx_cnt, tx_n, rx_cnt, rx_n;
  logic [2:0]    tx_idx, rx_idx;
  logic [7:0]    tx_shift, rx_shift;
  logic          rx_meta, rx_sync, rx_prev;

  logic [2:0]    sel;
  logic          acc, wr, rd, wr_txdata, wr_status, rd_rxdata;
  logic          tx_busy, tx_end, rx_end, rx_half_end, rx_done, rx_in;
  logic [CW-1:0] baud_eff;
  logic          unused_bits;

  assign sel       = paddr[4:2];
  assign acc       = psel & penable;
  assign wr        = acc & pwrite;
  assign rd        = acc & ~pwrite;
  assign wr_txdata = wr && (sel == A_TXDATA);
  assign wr_status = wr && (sel == A_STATUS);
  assign rd_rxdata = rd && (sel == A_RXDATA);
  assign pready    = acc;

  assign baud_eff    = (baud < MIN_N) ? MIN_N : baud;
  assign tx_busy     = (tx_state != S_IDLE);
  assign tx_end      = (tx_cnt == tx_n - ONE);
  assign rx_end      = (rx_cnt == rx_n - ONE);
  assign rx_half_end = (rx_cnt == (rx_n >> 1) - ONE);
  assign rx_done     = (rx_state == S_STOP) && rx_end;
  assign rx_in       = loopback ? uart_tx : rx_sync;
  assign unused_bits = ^{paddr[WIDTH-1:5], paddr[1:0], pwdata[WIDTH-1:CW]};

  // Read mux; only driven during a selected read
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (sel)
        A_BAUD:   prdata = WIDTH'(baud);
        A_STATUS: prdata = WIDTH'({rx_frame_err, rx_overrun, rx_valid, tx_busy});
        A_RXDATA: prdata = WIDTH'(rxdata);
        A_CTRL:   prdata = WIDTH'(loopback);
        default:  prdata = '0;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      baud     <= DEF_BAUD;
      loopback <= 1'b0;
    end else if (wr) begin
      if (sel == A_BAUD) baud     <= pwdata[CW-1:0];
      if (sel == A_CTRL) loopback <= pwdata[0];
    end
  end

  // Transmitter: bit period latched at frame start so BAUD writes affect the next frame
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_n     <= MIN_N;
      tx_idx   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (wr_txdata) begin
            tx_shift <= pwdata[7:0];
            tx_n     <= baud_eff;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            uart_tx  <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_end) begin
            tx_cnt   <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= S_DATA;
          end else tx_cnt <= tx_cnt + ONE;
        end
        S_DATA: begin
          if (tx_end) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else tx_cnt <= tx_cnt + ONE;
        end
        S_STOP: begin
          if (tx_end) begin
            tx_cnt   <= '0;
            tx_state <= S_IDLE;
          end else tx_cnt <= tx_cnt + ONE;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // Receiver: start edge, half-bit recheck, then one sample per bit period at mid-bit
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_n     <= MIN_N;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_in;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_in) begin
            rx_n     <= baud_eff;
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_half_end) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_in ? S_IDLE : S_DATA;
          end else rx_cnt <= rx_cnt + ONE;
        end
        S_DATA: begin
          if (rx_end) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_in, rx_shift[7:1]};
            if (rx_idx == 3'd7) rx_state <= S_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else rx_cnt <= rx_cnt + ONE;
        end
        S_STOP: begin
          if (rx_end) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else rx_cnt <= rx_cnt + ONE;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // Status flags: a new byte or flag set on the same edge beats a read/W1C clear
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      rxdata       <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_done)        rxdata <= rx_shift;
      if (rx_done)        rx_valid <= 1'b1;
      else if (rd_rxdata) rx_valid <= 1'b0;
      if (rx_done && rx_valid && !rd_rxdata) rx_overrun <= 1'b1;
      else if (wr_status && pwdata[2])       rx_overrun <= 1'b0;
      if (rx_done && !rx_in)                 rx_frame_err <= 1'b1;
      else if (wr_status && pwdata[3])       rx_frame_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_apb_uart_slave.sv
// Directed bench for apb_uart_slave: APB register access, loopback and external
// serial frames, checked against a byte scoreboard and an independent line decoder.
module tb_apb_uart_slave;
  localparam int unsigned WIDTH = 32;
  localparam logic [4:0] A_BAUD = 5'h00, A_TX = 5'h04, A_STATUS = 5'h08,
                         A_RX = 5'h0C, A_CTRL = 5'h10, A_UNMAP = 5'h1C;

  logic             pclk = 1'b0;
  logic             presetn;
  logic [WIDTH-1:0] paddr, pwdata, prdata;
  logic             psel, penable, pwrite, pready;
  logic             uart_rx, uart_tx;

  int         n_checks = 0, n_pass = 0, n_fail = 0;
  int         cyc = 0;
  int         tb_baud = 66;
  logic       last_pready;
  logic [7:0] sb[$];
  logic [7:0] mon_q[$];

  apb_uart_slave #(.WIDTH(WIDTH), .DEF_BAUD(11'd66)) dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pready(pready),
    .prdata(prdata), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'(a); pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'(a);
    @(posedge pclk); #1;
    penable = 1'b1;
    #3;
    d = prdata;
    last_pready = pready;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Poll one STATUS bit until it reaches v, bounded by a cycle budget
  task automatic wait_status(input int b, input logic v, input int budget, input string tag);
    logic [31:0] st;
    int t0;
    t0 = cyc;
    apb_read(A_STATUS, st);
    while (st[b] !== v && (cyc - t0) < budget) apb_read(A_STATUS, st);
    check(tag, 32'(st[b]), 32'(v));
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_status(0, 1'b0, 800, "tx_idle_before_send");
    apb_write(A_TX, 32'(b));
    sb.push_back(b);
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    apb_read(A_RX, d);
    e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    check(tag, d, 32'(e));
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (tb_baud) @(posedge pclk);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  // Independent decoder of the uart_tx line
  initial begin
    forever begin
      @(negedge uart_tx);
      if (presetn === 1'b1) begin : frame
        logic [7:0] b;
        int n;
        n = tb_baud;
        repeat (n / 2) @(posedge pclk);
        #1;
        if (uart_tx == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (n) @(posedge pclk);
            #1;
            b[i] = uart_tx;
          end
          repeat (n) @(posedge pclk);
          #1;
          if (uart_tx == 1'b1) mon_q.push_back(b);
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  t3 [3];
    t3 = '{8'h0E, 8'h4E, 8'h63};
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    uart_rx = 1'b1; presetn = 1'b0; last_pready = 1'b0;

    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    presetn = 1'b1;
    apb_read(A_BAUD, d);   check("rst_baud", d, 32'd66);
    check("access_pready", 32'(last_pready), 32'd1);
    apb_read(A_STATUS, d); check("rst_status", d, 32'd0);
    apb_read(A_CTRL, d);   check("rst_ctrl", d, 32'd0);
    apb_write(A_UNMAP, 32'hFFFF_FFFF);
    apb_read(A_UNMAP, d);  check("unmapped_read", d, 32'd0);

    // Single loopback byte
    apb_write(A_BAUD, 32'd66);
    apb_write(A_CTRL, 32'd1);
    apb_read(A_CTRL, d);   check("ctrl_readback", d, 32'd1);
    apb_write(A_TX, 32'h56);
    sb.push_back(8'h56);
    apb_read(A_STATUS, d); check("t2_tx_busy", 32'(d[0]), 32'd1);
    wait_status(1, 1'b1, 660, "t2_rx_valid");
    read_rx("t2_rxdata");
    apb_read(A_STATUS, d); check("t2_valid_cleared", 32'(d[1]), 32'd0);

    // Back-to-back loopback bytes
    foreach (t3[i]) begin
      send_byte(t3[i]);
      wait_status(1, 1'b1, 700, "t3_rx_valid");
      read_rx("t3_rxdata");
      apb_read(A_STATUS, d); check("t3_err_flags", 32'(d[3:2]), 32'd0);
    end

    // Overrun: second byte overwrites the unread first one
    send_byte(8'h11);
    send_byte(8'h22);
    wait_status(0, 1'b0, 800, "t4_tx_idle");
    void'(sb.pop_front());
    read_rx("t4_rxdata");
    apb_read(A_STATUS, d); check("t4_overrun", d, 32'h4);
    apb_write(A_STATUS, 32'h4);
    apb_read(A_STATUS, d); check("t4_overrun_w1c", d, 32'h0);

    // TXDATA write while busy is dropped
    wait_status(0, 1'b0, 800, "t5_tx_idle0");
    mon_q.delete();
    apb_write(A_TX, 32'hAA);
    sb.push_back(8'hAA);
    apb_write(A_TX, 32'h55);
    wait_status(1, 1'b1, 700, "t5_rx_valid");
    read_rx("t5_rxdata");
    wait_status(0, 1'b0, 800, "t5_tx_idle1");
    apb_read(A_STATUS, d); check("t5_status_clean", d, 32'h0);
    check("t5_line_frames", 32'(mon_q.size()), 32'd1);
    check("t5_line_byte", 32'((mon_q.size() != 0) ? mon_q[0] : 8'h00), 32'hAA);

    // External frame with a bad stop bit
    apb_write(A_CTRL, 32'd0);
    sb.push_back(8'h3C);
    drive_frame(8'h3C, 1'b0);
    wait_status(1, 1'b1, 200, "t5_ext_rx_valid");
    apb_read(A_STATUS, d); check("t5_frame_err", d, 32'hA);
    read_rx("t5_ext_rxdata");
    apb_write(A_STATUS, 32'h8);
    apb_read(A_STATUS, d); check("t5_frame_err_w1c", d, 32'h0);

    // BAUD below 2 behaves as 2
    apb_write(A_BAUD, 32'd1);
    apb_read(A_BAUD, d);   check("baud1_readback", d, 32'd1);
    tb_baud = 2;
    apb_write(A_CTRL, 32'd1);
    mon_q.delete();
    send_byte(8'h5A);
    wait_status(1, 1'b1, 100, "baud1_rx_valid");
    read_rx("baud1_rxdata");
    wait_status(0, 1'b0, 100, "baud1_tx_idle");
    check("baud1_line_byte", 32'((mon_q.size() != 0) ? mon_q[0] : 8'h00), 32'h5A);

    // Reset in the middle of a frame
    apb_write(A_BAUD, 32'd66);
    tb_baud = 66;
    apb_write(A_TX, 32'hFF);
    repeat (200) @(posedge pclk);
    #1;
    presetn = 1'b0;
    @(posedge pclk);
    #1;
    check("t6_uart_tx_idle", 32'(uart_tx), 32'd1);
    presetn = 1'b1;
    apb_read(A_STATUS, d); check("t6_status", d, 32'h0);
    apb_read(A_BAUD, d);   check("t6_baud_reset", d, 32'd66);
    repeat (700) @(posedge pclk);
    apb_read(A_STATUS, d); check("t6_no_rx_valid", d, 32'h0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global bound so the run can never hang
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
